// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller: FSM states,
// source count, code width and the fixed-priority encoder.
package int_ctrl_pkg;

    localparam int NSRC   = 3;
    localparam int CODE_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        SERVICE = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Highest set bit wins; result is the 1-based source number, 0 when none.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [NSRC-1:0] req);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (req[i]) idx = CODE_W'(i + 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_ctrl_pend_latch.sv
// One interrupt source: rising-edge detect on the device line and a pending
// flop where a new edge beats a same-cycle clear.
module irq_pend_latch (
    input  logic in_CLK,
    input  logic in_RST,
    input  logic in_irq,
    input  logic in_clr,
    output logic out_pend
);

    logic r_irq_q;
    logic r_pend;
    logic w_rise;

    assign w_rise   = in_irq & ~r_irq_q;
    assign out_pend = r_pend;

    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            r_irq_q <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_irq_q <= in_irq;
            if (w_rise)      r_pend <= 1'b1;
            else if (in_clr) r_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller top: fixed-priority arbitration against IE/INM, entry
// FSM with break pulse, nesting stack and handler vector generation.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0100
) (
    input  logic        in_CLK,
    input  logic        in_RST,
    input  logic [2:0]  in_IRQ,
    input  logic        in_IE,
    input  logic [3:0]  in_INM,
    input  logic        in_eret,
    output logic        out_BK,
    output logic        out_NIE,
    output logic [1:0]  out_code,
    output logic [31:0] out_vector,
    output logic [2:0]  out_pending,
    output logic [1:0]  out_state
);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [NSRC-1:0]              w_pending;
    logic [NSRC-1:0]              w_clr;
    logic [NSRC-1:0]              w_elig;
    logic [CODE_W-1:0]            w_cand;
    logic [CODE_W-1:0]            w_top;
    logic [2:0][CODE_W-1:0]       r_stack;
    logic [1:0]                   r_depth;
    logic [CODE_W-1:0]            r_code;
    logic [CODE_W-1:0]            w_code_nxt;
    logic                         r_bk;
    logic                         w_bk_nxt;
    logic                         r_nie;
    logic                         w_nie_nxt;
    logic [31:0]                  r_vector;
    logic [31:0]                  w_vector_nxt;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_unused_inm0;

    assign w_unused_inm0 = in_INM[0];

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_pend_latch u_pend (
            .in_CLK   (in_CLK),
            .in_RST   (in_RST),
            .in_irq   (in_IRQ[g]),
            .in_clr   (w_clr[g]),
            .out_pend (w_pending[g])
        );
    end

    assign w_elig = w_pending & ~in_INM[3:1];
    assign w_cand = prio_enc(w_elig);
    assign w_top  = (r_depth == 2'd0) ? '0 : r_stack[r_depth - 2'd1];

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_bk_nxt    = 1'b0;
        w_nie_nxt   = 1'b1;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clr       = '0;
        case (r_state)
            IDLE: begin
                if (in_IE && (w_cand != '0)) begin
                    w_state_nxt = ENTER;
                    w_code_nxt  = w_cand;
                    w_bk_nxt    = 1'b1;
                    w_nie_nxt   = 1'b0;
                    w_push      = 1'b1;
                end
            end
            ENTER: begin
                w_state_nxt = SERVICE;
            end
            SERVICE: begin
                // eret wins over preemption; preemption is re-checked next cycle.
                if (in_eret) begin
                    w_pop = 1'b1;
                    w_clr[r_code - 2'd1] = 1'b1;
                    if (r_depth <= 2'd1) begin
                        w_state_nxt = IDLE;
                        w_code_nxt  = '0;
                    end else begin
                        w_code_nxt = r_stack[r_depth - 2'd2];
                    end
                end else if (in_IE && (w_cand > r_code)) begin
                    w_state_nxt = GAP;
                    w_code_nxt  = '0;
                end
            end
            GAP: begin
                // If the preempting source vanished (masked), resume the interrupted level.
                if (w_cand > w_top) begin
                    w_state_nxt = ENTER;
                    w_code_nxt  = w_cand;
                    w_bk_nxt    = 1'b1;
                    w_nie_nxt   = 1'b0;
                    w_push      = 1'b1;
                end else begin
                    w_state_nxt = SERVICE;
                    w_code_nxt  = w_top;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (w_code_nxt == '0) w_vector_nxt = '0;
        else w_vector_nxt = VEC_BASE + (32'(w_code_nxt) - 32'd1) * VEC_STRIDE;
    end

    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            r_state  <= IDLE;
            r_code   <= '0;
            r_bk     <= 1'b0;
            r_nie    <= 1'b1;
            r_vector <= '0;
            r_stack  <= '0;
            r_depth  <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_code   <= w_code_nxt;
            r_bk     <= w_bk_nxt;
            r_nie    <= w_nie_nxt;
            r_vector <= w_vector_nxt;
            if (w_push) begin
                r_stack[r_depth] <= w_cand;
                r_depth          <= r_depth + 2'd1;
            end else if (w_pop) begin
                r_depth <= r_depth - 2'd1;
            end
        end
    end

    // Only strictly higher sources preempt, so depth never exceeds NSRC.
    a_no_push_full: assert property (@(posedge in_CLK) disable iff (!in_RST)
        !(w_push && (r_depth == 2'd3)));

    assign out_BK      = r_bk;
    assign out_NIE     = r_nie;
    assign out_code    = r_code;
    assign out_vector  = r_vector;
    assign out_pending = w_pending;
    assign out_state   = r_state;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: cycle-by-cycle vectors with hand-computed
// expected outputs, covering entry, priority, nesting, masking and reset.
module tb_int_ctrl;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENTER   = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  irq = 3'b000;
    logic        ie = 1'b0;
    logic [3:0]  inm = 4'b0000;
    logic        eret = 1'b0;
    logic        bk;
    logic        nie;
    logic [1:0]  code;
    logic [31:0] vector;
    logic [2:0]  pending;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;
    int step_n = 0;

    typedef struct {
        logic [2:0]  irq;
        logic        ie;
        logic [3:0]  inm;
        logic        eret;
        logic        bk;
        logic        nie;
        logic [1:0]  code;
        logic [31:0] vec;
        logic [2:0]  pend;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    int_ctrl #(
        .VEC_BASE   (32'h0000_1000),
        .VEC_STRIDE (32'h0000_0100)
    ) dut (
        .in_CLK      (clk),
        .in_RST      (rst_n),
        .in_IRQ      (irq),
        .in_IE       (ie),
        .in_INM      (inm),
        .in_eret     (eret),
        .out_BK      (bk),
        .out_NIE     (nie),
        .out_code    (code),
        .out_vector  (vector),
        .out_pending (pending),
        .out_state   (state)
    );

    function automatic vec_t row(input logic [2:0] r_irq, input logic r_ie,
                                 input logic [3:0] r_inm, input logic r_eret,
                                 input logic e_bk, input logic e_nie,
                                 input logic [1:0] e_code, input logic [31:0] e_vec,
                                 input logic [2:0] e_pend, input logic [1:0] e_st);
        vec_t v;
        v.irq = r_irq; v.ie = r_ie; v.inm = r_inm; v.eret = r_eret;
        v.bk = e_bk; v.nie = e_nie; v.code = e_code; v.vec = e_vec;
        v.pend = e_pend; v.st = e_st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step%0d %s got=%h exp=%h", step_n, nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let one edge pass, compare all outputs.
    task automatic do_step(input vec_t v, input logic rst_v);
        rst_n = rst_v;
        irq   = v.irq;
        ie    = v.ie;
        inm   = v.inm;
        eret  = v.eret;
        @(posedge clk);
        #1;
        step_n++;
        chk("bk",      32'(bk),      32'(v.bk));
        chk("nie",     32'(nie),     32'(v.nie));
        chk("code",    32'(code),    32'(v.code));
        chk("vector",  vector,       v.vec);
        chk("pending", 32'(pending), 32'(v.pend));
        chk("state",   32'(state),   32'(v.st));
    endtask

    initial begin
        #1;
        do_step(row(3'b000, 1, 4'b0000, 0, 0, 1, 0, 32'h0, 3'b000, S_IDLE), 1'b0);
        do_step(row(3'b000, 1, 4'b0000, 0, 0, 1, 0, 32'h0, 3'b000, S_IDLE), 1'b0);

        // single source 1: entry two edges after the rise, then eret
        tbl.push_back(row(3'b001, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b001, S_IDLE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 1, 0, 1, 32'h1000, 3'b001, S_ENTER));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 0, 1, 1, 32'h1000, 3'b001, S_SERVICE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 1, 0, 1, 0, 32'h0,    3'b000, S_IDLE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b000, S_IDLE));
        // sources 1 and 3 together: 3 first, then a fresh entry for 1
        tbl.push_back(row(3'b101, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b101, S_IDLE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 1, 0, 3, 32'h1200, 3'b101, S_ENTER));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 0, 1, 3, 32'h1200, 3'b101, S_SERVICE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 1, 0, 1, 0, 32'h0,    3'b001, S_IDLE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 1, 0, 1, 32'h1000, 3'b001, S_ENTER));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 0, 1, 1, 32'h1000, 3'b001, S_SERVICE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 1, 0, 1, 0, 32'h0,    3'b000, S_IDLE));
        // nesting: 1 in service, 2 preempts through GAP, two erets unwind
        tbl.push_back(row(3'b001, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b001, S_IDLE));
        tbl.push_back(row(3'b001, 1, 4'b0000, 0, 1, 0, 1, 32'h1000, 3'b001, S_ENTER));
        tbl.push_back(row(3'b011, 1, 4'b0000, 0, 0, 1, 1, 32'h1000, 3'b011, S_SERVICE));
        tbl.push_back(row(3'b011, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b011, S_GAP));
        tbl.push_back(row(3'b011, 1, 4'b0000, 0, 1, 0, 2, 32'h1100, 3'b011, S_ENTER));
        tbl.push_back(row(3'b011, 1, 4'b0000, 0, 0, 1, 2, 32'h1100, 3'b011, S_SERVICE));
        tbl.push_back(row(3'b011, 1, 4'b0000, 1, 0, 1, 1, 32'h1000, 3'b001, S_SERVICE));
        tbl.push_back(row(3'b011, 1, 4'b0000, 0, 0, 1, 1, 32'h1000, 3'b001, S_SERVICE));
        tbl.push_back(row(3'b011, 1, 4'b0000, 1, 0, 1, 0, 32'h0,    3'b000, S_IDLE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b000, S_IDLE));
        // masked source 2 stays pending until the mask drops
        tbl.push_back(row(3'b010, 1, 4'b0100, 0, 0, 1, 0, 32'h0,    3'b010, S_IDLE));
        tbl.push_back(row(3'b000, 1, 4'b0100, 0, 0, 1, 0, 32'h0,    3'b010, S_IDLE));
        tbl.push_back(row(3'b000, 1, 4'b0100, 0, 0, 1, 0, 32'h0,    3'b010, S_IDLE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 1, 0, 2, 32'h1100, 3'b010, S_ENTER));
        tbl.push_back(row(3'b000, 1, 4'b0000, 0, 0, 1, 2, 32'h1100, 3'b010, S_SERVICE));
        tbl.push_back(row(3'b000, 1, 4'b0000, 1, 0, 1, 0, 32'h0,    3'b000, S_IDLE));

        for (int i = 0; i < tbl.size(); i++) begin
            do_step(tbl[i], 1'b1);
        end

        // eret in IDLE is ignored; a rise coincident with eret keeps source 1 pending
        do_step(row(3'b000, 1, 4'b0000, 1, 0, 1, 0, 32'h0,    3'b000, S_IDLE), 1'b1);
        do_step(row(3'b001, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b001, S_IDLE), 1'b1);
        do_step(row(3'b000, 1, 4'b0000, 0, 1, 0, 1, 32'h1000, 3'b001, S_ENTER), 1'b1);
        do_step(row(3'b000, 0, 4'b0000, 0, 0, 1, 1, 32'h1000, 3'b001, S_SERVICE), 1'b1);
        do_step(row(3'b001, 0, 4'b0000, 1, 0, 1, 0, 32'h0,    3'b001, S_IDLE), 1'b1);
        do_step(row(3'b000, 0, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b001, S_IDLE), 1'b1);
        do_step(row(3'b000, 0, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b001, S_IDLE), 1'b1);
        do_step(row(3'b000, 1, 4'b0000, 0, 1, 0, 1, 32'h1000, 3'b001, S_ENTER), 1'b1);
        do_step(row(3'b000, 1, 4'b0000, 0, 0, 1, 1, 32'h1000, 3'b001, S_SERVICE), 1'b1);

        // reach depth 2, reset mid-service, then a clean entry/exit at depth 1
        do_step(row(3'b010, 1, 4'b0000, 0, 0, 1, 1, 32'h1000, 3'b011, S_SERVICE), 1'b1);
        do_step(row(3'b010, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b011, S_GAP), 1'b1);
        do_step(row(3'b010, 1, 4'b0000, 0, 1, 0, 2, 32'h1100, 3'b011, S_ENTER), 1'b1);
        do_step(row(3'b010, 1, 4'b0000, 0, 0, 1, 2, 32'h1100, 3'b011, S_SERVICE), 1'b1);
        do_step(row(3'b000, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b000, S_IDLE), 1'b0);
        do_step(row(3'b000, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b000, S_IDLE), 1'b1);
        do_step(row(3'b100, 1, 4'b0000, 0, 0, 1, 0, 32'h0,    3'b100, S_IDLE), 1'b1);
        do_step(row(3'b000, 1, 4'b0000, 0, 1, 0, 3, 32'h1200, 3'b100, S_ENTER), 1'b1);
        do_step(row(3'b000, 1, 4'b0000, 0, 0, 1, 3, 32'h1200, 3'b100, S_SERVICE), 1'b1);
        do_step(row(3'b000, 1, 4'b0000, 1, 0, 1, 0, 32'h0,    3'b000, S_IDLE), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
